// File: rtl/register_bank32.sv
`default_nettype none
// ============================================================================
//  Module   : register_bank32
//  Brief    : Storage half of the integer register file. 32 x 32-bit
//             registers with one synchronous write port; every register
//             drives its own output bus into the rs/rt read multiplexers.
//             Register 0 can be hardwired to zero ($zero convention).
//  Revision : 1.0 - initial release
// ============================================================================
module register_bank32 #(
  // Data width; the downstream read-port muxes are 32 bits wide, so keep 32.
  parameter int WIDTH    = 32,
  // 1: register 0 ignores writes and always reads zero.
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] Reg0,
  output logic [WIDTH-1:0] Reg1,
  output logic [WIDTH-1:0] Reg2,
  output logic [WIDTH-1:0] Reg3,
  output logic [WIDTH-1:0] Reg4,
  output logic [WIDTH-1:0] Reg5,
  output logic [WIDTH-1:0] Reg6,
  output logic [WIDTH-1:0] Reg7,
  output logic [WIDTH-1:0] Reg8,
  output logic [WIDTH-1:0] Reg9,
  output logic [WIDTH-1:0] Reg10,
  output logic [WIDTH-1:0] Reg11,
  output logic [WIDTH-1:0] Reg12,
  output logic [WIDTH-1:0] Reg13,
  output logic [WIDTH-1:0] Reg14,
  output logic [WIDTH-1:0] Reg15,
  output logic [WIDTH-1:0] Reg16,
  output logic [WIDTH-1:0] Reg17,
  output logic [WIDTH-1:0] Reg18,
  output logic [WIDTH-1:0] Reg19,
  output logic [WIDTH-1:0] Reg20,
  output logic [WIDTH-1:0] Reg21,
  output logic [WIDTH-1:0] Reg22,
  output logic [WIDTH-1:0] Reg23,
  output logic [WIDTH-1:0] Reg24,
  output logic [WIDTH-1:0] Reg25,
  output logic [WIDTH-1:0] Reg26,
  output logic [WIDTH-1:0] Reg27,
  output logic [WIDTH-1:0] Reg28,
  output logic [WIDTH-1:0] Reg29,
  output logic [WIDTH-1:0] Reg30,
  output logic [WIDTH-1:0] Reg31
);

  localparam int c_NUM_REGS = 32;

  // Flop outputs of every register, gathered so the port fan-out is uniform.
  logic [WIDTH-1:0] w_regs [c_NUM_REGS];

  for (genvar n = 0; n < c_NUM_REGS; n++) begin : g_reg
    if ((n == 0) && ZERO_REG) begin : g_zero
      // $zero: no enable, no storage; the bus is tied low permanently and
      // writes to index 0 vanish without any indication.
      assign w_regs[n] = '0;
    end else begin : g_store
      logic             w_en;
      logic [WIDTH-1:0] reg_d;
      logic [WIDTH-1:0] reg_q;

      // One-hot decode slice gated by RegWrite. With RegWrite low the AND
      // resolves to 0 even if WriteRegister is unknown, so X addresses
      // cannot disturb the stored value.
      assign w_en = RegWrite && (WriteRegister == 5'(n));

      // Next state: load WriteData when selected, otherwise hold.
      always_comb begin
        reg_d = reg_q;
        if (w_en) begin
          reg_d = WriteData;
        end
      end

      // Storage flop; reset clears it immediately and overrides any write.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign w_regs[n] = reg_q;
    end
  end

  // Outputs are the flop values directly; no input reaches them
  // combinationally, so a same-cycle read sees the pre-write value.
  assign Reg0  = w_regs[0];
  assign Reg1  = w_regs[1];
  assign Reg2  = w_regs[2];
  assign Reg3  = w_regs[3];
  assign Reg4  = w_regs[4];
  assign Reg5  = w_regs[5];
  assign Reg6  = w_regs[6];
  assign Reg7  = w_regs[7];
  assign Reg8  = w_regs[8];
  assign Reg9  = w_regs[9];
  assign Reg10 = w_regs[10];
  assign Reg11 = w_regs[11];
  assign Reg12 = w_regs[12];
  assign Reg13 = w_regs[13];
  assign Reg14 = w_regs[14];
  assign Reg15 = w_regs[15];
  assign Reg16 = w_regs[16];
  assign Reg17 = w_regs[17];
  assign Reg18 = w_regs[18];
  assign Reg19 = w_regs[19];
  assign Reg20 = w_regs[20];
  assign Reg21 = w_regs[21];
  assign Reg22 = w_regs[22];
  assign Reg23 = w_regs[23];
  assign Reg24 = w_regs[24];
  assign Reg25 = w_regs[25];
  assign Reg26 = w_regs[26];
  assign Reg27 = w_regs[27];
  assign Reg28 = w_regs[28];
  assign Reg29 = w_regs[29];
  assign Reg30 = w_regs[30];
  assign Reg31 = w_regs[31];

endmodule
`default_nettype wire

// File: tb/tb_register_bank32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_bank32
//  Brief    : Directed self-checking bench for register_bank32.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_register_bank32;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [31:0] regs_o [32];

  // Expected register contents, maintained by hand alongside the stimulus.
  logic [31:0] exp_regs [32];

  int tests_run;
  int tests_failed;

  register_bank32 #(.WIDTH(32), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .Reg0(regs_o[0]),   .Reg1(regs_o[1]),   .Reg2(regs_o[2]),   .Reg3(regs_o[3]),
    .Reg4(regs_o[4]),   .Reg5(regs_o[5]),   .Reg6(regs_o[6]),   .Reg7(regs_o[7]),
    .Reg8(regs_o[8]),   .Reg9(regs_o[9]),   .Reg10(regs_o[10]), .Reg11(regs_o[11]),
    .Reg12(regs_o[12]), .Reg13(regs_o[13]), .Reg14(regs_o[14]), .Reg15(regs_o[15]),
    .Reg16(regs_o[16]), .Reg17(regs_o[17]), .Reg18(regs_o[18]), .Reg19(regs_o[19]),
    .Reg20(regs_o[20]), .Reg21(regs_o[21]), .Reg22(regs_o[22]), .Reg23(regs_o[23]),
    .Reg24(regs_o[24]), .Reg25(regs_o[25]), .Reg26(regs_o[26]), .Reg27(regs_o[27]),
    .Reg28(regs_o[28]), .Reg29(regs_o[29]), .Reg30(regs_o[30]), .Reg31(regs_o[31])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s.Reg%0d", tag, i), regs_o[i], exp_regs[i]);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
  endtask

  // Drive one cycle's inputs at the falling edge, let the rising edge
  // act, then sample 1 time unit later.
  task automatic cycle(input logic we, input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    RegWrite      = we;
    WriteRegister = idx;
    WriteData     = data;
    @(posedge clk);
    #1;
    if (we && idx != 5'd0) exp_regs[idx] = data;
  endtask

  // Downstream read-port mux model (rs/rt side).
  function automatic logic [31:0] read_mux(input logic [4:0] sel);
    return regs_o[sel];
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clear_model();

    // Reset held while a write is being presented: nothing may load.
    reset         = 1'b1;
    RegWrite      = 1'b1;
    WriteRegister = 5'd3;
    WriteData     = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_hold_write");

    // Release reset away from an edge; first edge afterwards must write.
    @(negedge clk);
    reset    = 1'b0;
    RegWrite = 1'b0;
    cycle(1'b1, 5'd3, 32'h33333333);
    check_all("first_write_after_reset");

    // Walk: Reg n <= 0x1000_0000 + n for n = 1..31.
    for (int n = 1; n < 32; n++) begin
      cycle(1'b1, 5'(n), 32'h1000_0000 + 32'(n));
      check_all($sformatf("walk%0d", n));
    end

    // Write to index 0 is discarded.
    cycle(1'b1, 5'd0, 32'hFFFFFFFF);
    check_all("zero_reg_write");

    // Bit-exact extremes.
    cycle(1'b1, 5'd4, 32'h00000000);
    cycle(1'b1, 5'd6, 32'hFFFFFFFF);
    check_all("data_extremes");

    // Write disabled for 4 cycles.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 5'd5, 32'h12345678);
    end
    check("disable.Reg5", regs_o[5], 32'h10000005);
    check_all("write_disable");

    // Unknown address while disabled must not corrupt anything.
    cycle(1'b0, 5'bxxxxx, 32'hBAD0BAD0);
    check_all("x_addr_disabled");

    // Back-to-back writes to the same index.
    cycle(1'b1, 5'd9, 32'hA5A5A5A5);
    check("b2b.edge1.Reg9", regs_o[9], 32'hA5A5A5A5);
    cycle(1'b1, 5'd9, 32'h5A5A5A5A);
    check("b2b.edge2.Reg9", regs_o[9], 32'h5A5A5A5A);
    check("b2b.Reg8", regs_o[8], 32'h10000008);
    check("b2b.Reg10", regs_o[10], 32'h1000000A);

    // Index 31 boundary.
    cycle(1'b1, 5'd31, 32'h0F0F0F0F);
    check_all("idx31");

    // Asynchronous reset between edges clears everything immediately.
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    clear_model();
    check_all("async_reset_mid_cycle");
    @(negedge clk);
    reset    = 1'b0;
    RegWrite = 1'b0;

    // Read-mux integration: no bypass before the edge, new value after.
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd17;
    WriteData     = 32'hCAFEF00D;
    #1;
    check("mux.before_edge", read_mux(5'd17), 32'h00000000);
    @(posedge clk);
    #1;
    exp_regs[17] = 32'hCAFEF00D;
    check("mux.after_edge", read_mux(5'd17), 32'hCAFEF00D);
    cycle(1'b0, 5'd0, 32'h0);
    check_all("post_mux");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
